// File: rtl/alu_decode_stage_if.sv
// Handshake and writeback bundle between the fetch side, the decode stage and the execute stage.
interface alu_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [3:0]      out_op;
    logic [4:0]      out_rd;
    logic            out_we;
    logic            out_illegal;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, out_a, out_b, out_op, out_rd, out_we, out_illegal
    );

    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, out_a, out_b, out_op, out_rd, out_we, out_illegal
    );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I OP/OP-IMM decode and operand fetch with a one-entry registered output to the ALU.
// state | meaning
// EMPTY | no instruction held, out_valid=0
// FULL  | decoded instruction held for execute, out_valid=1
module alu_decode_stage #(
    parameter int       XLEN       = 32,
    parameter int       NUM_REGS   = 32,
    parameter logic [3:0] ILLEGAL_OP = 4'hF
) (
    input  logic clk,
    input  logic rst,
    alu_decode_stage_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    state_t state_q, state_d;
    logic   capture;

    logic [XLEN-1:0] rf_q [NUM_REGS];
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic [4:0]      rd_q;
    logic            we_q, we_d, ill_q, ill_d;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_s, shamt;
    logic            legal;

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign funct3 = bus.in_instr[14:12];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];
    assign funct7 = bus.in_instr[31:25];
    assign imm_s  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign shamt  = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};

    assign capture = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (capture) state_d = FULL;
            FULL:  if (bus.out_ready && !capture) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        bus.out_valid = (state_q == FULL);
        bus.in_ready  = (state_q == EMPTY) || bus.out_ready;
    end

    // Writeback in the capture cycle is forwarded so the operand sees the new value.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) rs1_val = (bus.wb_en && bus.wb_addr == rs1) ? bus.wb_data : rf_q[rs1];
        if (rs2 != 5'd0) rs2_val = (bus.wb_en && bus.wb_addr == rs2) ? bus.wb_data : rf_q[rs2];
    end

    always_comb begin
        legal = 1'b0;
        op_d  = ILLEGAL_OP;
        b_d   = '0;
        if (opcode == OPC_OP) begin
            b_d   = rs2_val;
            legal = 1'b1;
            if (funct7 == 7'b0000000) begin
                case (funct3)
                    3'b000:  op_d = 4'h0;
                    3'b111:  op_d = 4'h2;
                    3'b110:  op_d = 4'h3;
                    3'b100:  op_d = 4'h4;
                    3'b001:  op_d = 4'h5;
                    3'b101:  op_d = 4'h6;
                    default: legal = 1'b0;
                endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                op_d = 4'h1;
            end else begin
                legal = 1'b0;
            end
        end else if (opcode == OPC_OP_IMM) begin
            b_d   = imm_s;
            legal = 1'b1;
            case (funct3)
                3'b000:  op_d = 4'h0;
                3'b111:  op_d = 4'h2;
                3'b110:  op_d = 4'h3;
                3'b100:  op_d = 4'h4;
                3'b001:  begin op_d = 4'h5; b_d = shamt; legal = (funct7 == 7'b0000000); end
                3'b101:  begin op_d = 4'h6; b_d = shamt; legal = (funct7 == 7'b0000000); end
                default: legal = 1'b0;
            endcase
        end
        a_d   = rs1_val;
        ill_d = !legal;
        we_d  = legal && (rd != 5'd0);
        if (!legal) begin
            op_d = ILLEGAL_OP;
            a_d  = '0;
            b_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 4'h0;
            rd_q  <= '0;
            we_q  <= 1'b0;
            ill_q <= 1'b0;
        end else if (capture) begin
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            rd_q  <= rd;
            we_q  <= we_d;
            ill_q <= ill_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
            rf_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign bus.out_a       = a_q;
    assign bus.out_b       = b_q;
    assign bus.out_op      = op_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_we      = we_q;
    assign bus.out_illegal = ill_q;
endmodule
